vga_timing: RTL and testbench
=============================

// Module: vga_timing
// PURPOSE
//   Generates VGA raster timing for the display path. Produces pixel coords
//   (x, y) and the candraw visible-area flag consumed by renderer, plus the
//   active-low vga_hs/vga_vs syncs, delayed to align with renderer's
//   registered RGB/vga_blank outputs. Sits directly upstream of renderer;
//   clk is the pixel clock (25 MHz for 640x480@60).
// PARAMETERS
//   H_VISIBLE   640  visible pixels per line
//   H_FRONT     16   horizontal front porch (clocks)
//   H_SYNC      96   horizontal sync width (clocks)
//   H_BACK      48   horizontal back porch (clocks)
//   V_VISIBLE   480  visible lines per frame
//   V_FRONT     10   vertical front porch (lines)
//   V_SYNC      2    vertical sync width (lines)
//   V_BACK      33   vertical back porch (lines)
//   SYNC_DELAY  1    extra clocks on vga_hs/vga_vs (renderer latency), 0..4
// PORTS
//   clk          in   1   pixel clock, all logic on posedge
//   n_reset      in   1   asynchronous, active-low reset
//   x            out  11  horizontal count, 0..H_TOTAL-1
//   y            out  11  vertical count, 0..V_TOTAL-1
//   candraw      out  1   1 when x<H_VISIBLE and y<V_VISIBLE
//   vga_hs       out  1   horizontal sync, active low
//   vga_vs       out  1   vertical sync, active low
//   frame_start  out  1   1-cycle pulse when (x,y)==(0,0)
// BEHAVIOUR
//   - H_TOTAL=H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
//     Both must be <=2048 (11-bit counters); totals are elaborated constants.
//   - Internal h_cnt, v_cnt (11b). Each clk: h_cnt==H_TOTAL-1 -> h_cnt=0 and
//     v_cnt advances (v_cnt==V_TOTAL-1 -> 0); else h_cnt+1. No free states.
//   - Outputs are registers loaded each clk from decode of current h_cnt/v_cnt,
//     so x/y/candraw/frame_start are mutually coherent, lag counters 1 clk.
//   - x=h_cnt, y=v_cnt in all regions (incl. blanking); consumers gate on candraw.
//   - hs_raw low when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC;
//     vs_raw low when V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC
//     (whole lines, changes at h_cnt==0). Raw syncs pass the output register
//     plus SYNC_DELAY-stage shift register (preset 1) -> vga_hs/vga_vs.
//     Net: vga_hs at cycle t equals hs decode of the x shown at t-SYNC_DELAY.
//   - Reset (n_reset low, async): h_cnt=v_cnt=0, x=0, y=0, candraw=0,
//     frame_start=0, vga_hs=1, vga_vs=1, sync shift regs all 1.
//   - First posedge after release: x=0,y=0,candraw=1,frame_start=1; counters 1.
//   - Reset asserted mid-frame: outputs return to reset values immediately,
//     restart from (0,0) on release; no partial line/sync carried over.
//   - frame_start high for exactly one clk per frame (every H_TOTAL*V_TOTAL).
// TESTING
//   1 Reset held 5 clks -> x=0,y=0,candraw=0,vga_hs=1,vga_vs=1,frame_start=0.
//   2 Release; first line -> x steps 0..639 with candraw=1, x=640 candraw=0,
//     x=799 then x=0,y=1; frame_start only at first (0,0).
//   3 Hsync: vga_hs low for exactly 96 clks, first low cycle 1 clk after x=656
//     shown (SYNC_DELAY=1), high again 1 clk after x=752 shown.
//   4 Vsync: vga_vs low for 1600 clks spanning y=490..491 (delayed 1 clk);
//     candraw=0 for all y>=480; frame wraps (799,524)->(0,0), frame_start=1.
//   5 Assert n_reset at (x=300,y=200), between edges -> outputs reset at once;
//     release -> restart (0,0) with frame_start=1.
//   6 Params H 8/2/2/2, V 4/1/1/1, SYNC_DELAY=0 -> period 14x7=98 clks,
//     vga_hs low same clk x=10..11 shown, frame_start every 98 clks.

Source files
------------

// File: rtl/vga_timing.sv
// vga_timing: raster counters driving registered pixel coords, visible flag, frame pulse and delayed active-low syncs
module vga_timing #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic        clk,
  input  logic        n_reset,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        candraw,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, x_q, y_q;
  logic candraw_q, frame_start_q, hs_raw, vs_raw;
  // bit 0 is the output register of the raw decode, higher bits delay it to match renderer latency
  logic [SYNC_DELAY:0] hs_q, vs_q;
  // next counter values and sync decode of the current raster position
  always_comb begin
    h_cnt_d = (h_cnt_q == H_LAST) ? '0 : h_cnt_q + 11'd1;
    v_cnt_d = (h_cnt_q != H_LAST) ? v_cnt_q : (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
    hs_raw  = !(h_cnt_q >= HS_BEG && h_cnt_q < HS_END);
    vs_raw  = !(v_cnt_q >= VS_BEG && v_cnt_q < VS_END);
  end
  // counters advance every pixel clock; outputs register the decode of the pre-edge count
  always_ff @(posedge clk or negedge n_reset)
    if (!n_reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      candraw_q     <= 1'b0;
      frame_start_q <= 1'b0;
      hs_q          <= '1;
      vs_q          <= '1;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      x_q           <= h_cnt_q;
      y_q           <= v_cnt_q;
      candraw_q     <= h_cnt_q < H_VIS && v_cnt_q < V_VIS;
      frame_start_q <= h_cnt_q == '0 && v_cnt_q == '0;
      hs_q          <= (hs_q << 1) | (SYNC_DELAY + 1)'(hs_raw);
      vs_q          <= (vs_q << 1) | (SYNC_DELAY + 1)'(vs_raw);
    end
  assign x           = x_q;
  assign y           = y_q;
  assign candraw     = candraw_q;
  assign frame_start = frame_start_q;
  assign vga_hs      = hs_q[SYNC_DELAY];
  assign vga_vs      = vs_q[SYNC_DELAY];
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard plus vector table checking two vga_timing configurations
module tb_vga_timing;
  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic cd, hs, vs, fs;
  } out_t;
  typedef struct {
    int   cyc;
    out_t exp;
  } vec_t;
  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic [10:0] ax, ay, bx, by;
  logic acd, ahs, avs, afs, bcd, bhs, bvs, bfs;
  int tests = 0, fails = 0, k = 0, hs_run = 0, vs_run = 0, last_fs_b = 0;
  out_t qa[$], qb[$];
  vec_t tv[$];
  out_t rst_v;
  vga_timing #(.V_VISIBLE(20), .V_FRONT(3), .V_SYNC(2), .V_BACK(4)) u_a (
    .clk(clk), .n_reset(n_reset), .x(ax), .y(ay), .candraw(acd),
    .vga_hs(ahs), .vga_vs(avs), .frame_start(afs)
  );
  vga_timing #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2), .V_VISIBLE(4),
               .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_DELAY(0)) u_b (
    .clk(clk), .n_reset(n_reset), .x(bx), .y(by), .candraw(bcd),
    .vga_hs(bhs), .vga_vs(bvs), .frame_start(bfs)
  );
  always #5 clk = ~clk;
  // expected outputs after the n-th edge since reset release (n=0: still in reset)
  function automatic out_t model(int n, int hv, int hf, int hsy, int hb, int vv, int vf, int vsy, int vb, int sd);
    int ht = hv + hf + hsy + hb;
    int ft = ht * (vv + vf + vsy + vb);
    int p, d;
    out_t o = '0;
    o.hs = 1'b1;
    o.vs = 1'b1;
    if (n == 0) return o;
    p = (n - 1) % ft;
    o.x  = 11'(p % ht);
    o.y  = 11'(p / ht);
    o.cd = (p % ht < hv) && (p / ht < vv);
    o.fs = (p == 0);
    if (n - 1 >= sd) begin
      d = (n - 1 - sd) % ft;
      o.hs = !((d % ht) >= hv + hf && (d % ht) < hv + hf + hsy);
      o.vs = !((d / ht) >= vv + vf && (d / ht) < vv + vf + vsy);
    end
    return o;
  endfunction
  function automatic vec_t v(int c, int xx, int yy, bit cd, bit hs, bit vs, bit fs);
    vec_t r;
    r.cyc = c;
    r.exp = {11'(xx), 11'(yy), cd, hs, vs, fs};
    return r;
  endfunction
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  // one clock: push expectations at the edge, compare at the following negedge
  task automatic tick();
    @(posedge clk);
    if (n_reset) k++;
    qa.push_back(model(k, 640, 16, 96, 48, 20, 3, 2, 4, 1));
    qb.push_back(model(k, 8, 2, 2, 2, 4, 1, 1, 1, 0));
    @(negedge clk);
    chk("sb_a", 32'({ax, ay, acd, ahs, avs, afs}), 32'(qa.pop_front()));
    chk("sb_b", 32'({bx, by, bcd, bhs, bvs, bfs}), 32'(qb.pop_front()));
    if (!ahs) hs_run++;
    else if (hs_run > 0) begin
      chk("hs_low_len", 32'(hs_run), 32'd96);
      hs_run = 0;
    end
    if (!avs) vs_run++;
    else if (vs_run > 0) begin
      chk("vs_low_len", 32'(vs_run), 32'd1600);
      vs_run = 0;
    end
    if (n_reset && k > 0) chk("b_hs_x", 32'(bhs), 32'(!(bx == 11'd10 || bx == 11'd11)));
    if (bfs) begin
      if (last_fs_b > 0) chk("b_fs_period", 32'(k - last_fs_b), 32'd98);
      last_fs_b = k;
    end
  endtask
  initial begin
    rst_v = '0;
    rst_v.hs = 1'b1;
    rst_v.vs = 1'b1;
    tv.push_back(v(1, 0, 0, 1, 1, 1, 1));
    tv.push_back(v(2, 1, 0, 1, 1, 1, 0));
    tv.push_back(v(640, 639, 0, 1, 1, 1, 0));
    tv.push_back(v(641, 640, 0, 0, 1, 1, 0));
    tv.push_back(v(657, 656, 0, 0, 1, 1, 0));
    tv.push_back(v(658, 657, 0, 0, 0, 1, 0));
    tv.push_back(v(753, 752, 0, 0, 0, 1, 0));
    tv.push_back(v(754, 753, 0, 0, 1, 1, 0));
    tv.push_back(v(800, 799, 0, 0, 1, 1, 0));
    tv.push_back(v(801, 0, 1, 1, 1, 1, 0));
    tv.push_back(v(18401, 0, 23, 0, 1, 1, 0));
    tv.push_back(v(18402, 1, 23, 0, 1, 0, 0));
    tv.push_back(v(20001, 0, 25, 0, 1, 0, 0));
    tv.push_back(v(20002, 1, 25, 0, 1, 1, 0));
    tv.push_back(v(23200, 799, 28, 0, 1, 1, 0));
    tv.push_back(v(23201, 0, 0, 1, 1, 1, 1));
    repeat (5) tick();
    chk("rst_hold_a", 32'({ax, ay, acd, ahs, avs, afs}), 32'(rst_v));
    #1 n_reset = 1'b1;
    foreach (tv[i]) begin
      while (k < tv[i].cyc) tick();
      chk($sformatf("vec%0d", i), 32'({ax, ay, acd, ahs, avs, afs}), 32'(tv[i].exp));
    end
    while (k < 31501) tick();
    chk("pre_rst_pos", 32'({ax, ay}), 32'({11'd300, 11'd10}));
    #1 n_reset = 1'b0;
    k = 0;
    hs_run = 0;
    vs_run = 0;
    last_fs_b = 0;
    #1;
    chk("rst_async_a", 32'({ax, ay, acd, ahs, avs, afs}), 32'(rst_v));
    chk("rst_async_b", 32'({bx, by, bcd, bhs, bvs, bfs}), 32'(rst_v));
    repeat (3) tick();
    #1 n_reset = 1'b1;
    tick();
    chk("restart_a", 32'({ax, ay, acd, ahs, avs, afs}), 32'({11'd0, 11'd0, 4'b1111}));
    chk("restart_b", 32'({bx, by, bcd, bhs, bvs, bfs}), 32'({11'd0, 11'd0, 4'b1111}));
    repeat (300) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
